// File: rtl/grand_adder_pipe.sv
// FMA final adder: CSA sum/carry add, addend-high increment, magnitude select,
// leading-zero count. Two registered stages with valid/ready backpressure.
module grand_adder_pipe #(
  parameter int PARM_MANT = 23
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [2*PARM_MANT+1:0]              CSA_sum_i,
  input  logic [2*PARM_MANT+1:0]              CSA_carry_i,
  input  logic                                Carry_corr_i,
  input  logic                                Sub_Sign_i,
  input  logic                                Exp_mv_sign_i,
  input  logic                                Mv_halt_i,
  input  logic                                Sign_aligned_i,
  input  logic [PARM_MANT+3:0]                A_Mant_aligned_high_i,
  input  logic                                Bc_special_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [3*PARM_MANT+4:0]              PosSum_o,
  output logic                                Adder_sign_o,
  output logic                                Sign_flip_o,
  output logic                                Minus_sticky_bit_o,
  output logic [$clog2(3*PARM_MANT+6)-1:0]    Lzc_o,
  output logic                                Zero_o
);

  localparam int WL = 2*PARM_MANT + 2;
  localparam int WH = PARM_MANT + 4;
  localparam int WS = 3*PARM_MANT + 5;
  localparam int WZ = $clog2(WS + 1);
  localparam int WT = WH + WL;

  // Two's-complement negation of the low WS bits equals the low WS bits of -T.
  function automatic logic [WS-1:0] neg_mag(input logic signed [WS-1:0] v);
    logic signed [WS-1:0] n;
    n = -v;
    return n;
  endfunction

  // Product-absent subtraction: addend shifted up with a borrow unless B/C is special.
  function automatic logic [WS-1:0] ems_sub_mag(input logic [WH-1:0] a, input logic bc);
    logic [WS-1:0] base;
    base = WS'({a[WH-2:0], 1'b0}) - WS'(!bc);
    return base << (2*PARM_MANT + 1);
  endfunction

  function automatic logic [WZ-1:0] count_lz(input logic [WS-1:0] v);
    logic [WZ-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = WS-1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + WZ'(1);
      end
    end
    return n;
  endfunction

  logic s1_adv;
  logic accept;

  logic            vld_p1, vld_p2;
  logic            lc_p1;
  logic [WL-1:0]   ls_p1;
  logic [WH-1:0]   a_high_p1;
  logic            sub_p1, ems_p1, halt_p1, sa_p1, bc_p1;

  logic [WS-1:0]   pos_sum_p2;
  logic            adder_sign_p2, flip_p2, sticky_p2, zero_p2;
  logic [WZ-1:0]   lzc_p2;

  logic unused_carry_msb;
  assign unused_carry_msb = CSA_carry_i[WL-1];

  assign s1_adv  = ~vld_p2 | ready_i;
  assign ready_o = ~vld_p1 | s1_adv;
  assign accept  = valid_i & ready_o;

  // ---- stage 0: carry-vector assembly and low add ----
  logic [WL:0] cv_p0;
  logic [WL:0] low_p0;

  assign cv_p0  = {(Exp_mv_sign_i ? 1'b0 : Carry_corr_i), CSA_carry_i[WL-2:0], Sub_Sign_i};
  assign low_p0 = {1'b0, CSA_sum_i} + cv_p0;

  // ---- stage 1: high increment, sign detect, magnitude select ----
  logic [WH-1:0]        hi_sum_p1;
  logic signed [WT-1:0] t_p1;
  logic                 flip_p1;
  logic [WS-1:0]        mag_p1;
  logic                 adder_sign_p1;

  assign hi_sum_p1 = a_high_p1 + WH'(lc_p1);
  assign t_p1      = {hi_sum_p1, ls_p1};
  assign flip_p1   = t_p1[WT-1];

  always_comb begin
    mag_p1 = t_p1[WS-1:0];
    if (halt_p1)
      mag_p1 = WS'(ls_p1);
    else if (ems_p1 && sub_p1)
      mag_p1 = ems_sub_mag(a_high_p1, bc_p1);
    else if (ems_p1)
      mag_p1 = {a_high_p1[WH-2:0], {WL{1'b0}}};
    else if (flip_p1)
      mag_p1 = neg_mag(t_p1[WS-1:0]);
  end

  assign adder_sign_p1 = ems_p1 ? sa_p1 : (flip_p1 ^ sa_p1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      lc_p1         <= 1'b0;
      ls_p1         <= '0;
      a_high_p1     <= '0;
      sub_p1        <= 1'b0;
      ems_p1        <= 1'b0;
      halt_p1       <= 1'b0;
      sa_p1         <= 1'b0;
      bc_p1         <= 1'b0;
      pos_sum_p2    <= '0;
      adder_sign_p2 <= 1'b0;
      flip_p2       <= 1'b0;
      sticky_p2     <= 1'b0;
      lzc_p2        <= '0;
      zero_p2       <= 1'b0;
    end else begin
      if (ready_o) vld_p1 <= valid_i;
      if (accept) begin
        lc_p1     <= low_p0[WL];
        ls_p1     <= low_p0[WL-1:0];
        a_high_p1 <= A_Mant_aligned_high_i;
        sub_p1    <= Sub_Sign_i;
        ems_p1    <= Exp_mv_sign_i;
        halt_p1   <= Mv_halt_i;
        sa_p1     <= Sign_aligned_i;
        bc_p1     <= Bc_special_i;
      end
      // ---- stage 2: registered outputs ----
      if (s1_adv) vld_p2 <= vld_p1;
      if (vld_p1 && s1_adv) begin
        pos_sum_p2    <= mag_p1;
        adder_sign_p2 <= adder_sign_p1;
        flip_p2       <= flip_p1;
        sticky_p2     <= ems_p1 & ~bc_p1;
        lzc_p2        <= count_lz(mag_p1);
        zero_p2       <= (mag_p1 == '0);
      end
    end
  end

  assign valid_o            = vld_p2;
  assign PosSum_o           = pos_sum_p2;
  assign Adder_sign_o       = adder_sign_p2;
  assign Sign_flip_o        = flip_p2;
  assign Minus_sticky_bit_o = sticky_p2;
  assign Lzc_o              = lzc_p2;
  assign Zero_o             = zero_p2;

endmodule

// File: tb/tb_grand_adder_pipe.sv
// Self-checking bench for grand_adder_pipe (M=23): directed cases, stall,
// throughput, mid-flight reset and a randomized scoreboard run.
module tb_grand_adder_pipe;

  localparam int M  = 23;
  localparam int WL = 2*M + 2;
  localparam int WH = M + 4;
  localparam int WS = 3*M + 5;
  localparam int WZ = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0, ready_i = 1'b1;
  logic ready_o, valid_o;
  logic [WL-1:0] csa_sum = '0, csa_carry = '0;
  logic carry_corr = 0, sub_sign = 0, exp_mv_sign = 0, mv_halt = 0, sign_aligned = 0, bc_special = 0;
  logic [WH-1:0] a_high = '0;
  logic [WS-1:0] pos_sum;
  logic adder_sign, sign_flip, minus_sticky, zero;
  logic [WZ-1:0] lzc;

  typedef struct {
    logic [WL-1:0] s, c;
    logic cc, sub, ems, halt, sa, bc;
    logic [WH-1:0] a;
  } beat_t;

  typedef struct packed {
    logic [WS-1:0] pos;
    logic asign, flip, sticky;
    logic [WZ-1:0] lzc;
    logic zero;
  } res_t;

  int n_cmp = 0, n_err = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  grand_adder_pipe #(.PARM_MANT(M)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .CSA_sum_i(csa_sum), .CSA_carry_i(csa_carry), .Carry_corr_i(carry_corr),
    .Sub_Sign_i(sub_sign), .Exp_mv_sign_i(exp_mv_sign), .Mv_halt_i(mv_halt),
    .Sign_aligned_i(sign_aligned), .A_Mant_aligned_high_i(a_high),
    .Bc_special_i(bc_special), .valid_o(valid_o), .ready_i(ready_i),
    .PosSum_o(pos_sum), .Adder_sign_o(adder_sign), .Sign_flip_o(sign_flip),
    .Minus_sticky_bit_o(minus_sticky), .Lzc_o(lzc), .Zero_o(zero)
  );

  // Reference: whole-number arithmetic with explicit moduli.
  function automatic res_t model(input beat_t b);
    logic [127:0] cv, low, t, mag, v;
    int bits;
    res_t r;
    cv  = (128'(b.ems ? 1'b0 : b.cc) << 48) + (128'(b.c[46:0]) << 1) + 128'(b.sub);
    low = (128'(b.s) + cv) % (128'd1 << 49);
    t   = ((128'(b.a) << 48) + low) % (128'd1 << 75);
    r.flip = (t >= (128'd1 << 74));
    if (b.halt)               mag = low % (128'd1 << 48);
    else if (b.ems && b.sub)  mag = (((128'(b.a) % (128'd1 << 26)) * 2 - (b.bc ? 128'd0 : 128'd1)) << 47) % (128'd1 << 74);
    else if (b.ems)           mag = (128'(b.a) % (128'd1 << 26)) << 48;
    else if (r.flip)          mag = ((128'd1 << 75) - t) % (128'd1 << 74);
    else                      mag = t;
    r.pos    = mag[WS-1:0];
    r.asign  = b.ems ? b.sa : (r.flip ^ b.sa);
    r.sticky = b.ems & ~b.bc;
    v = mag; bits = 0;
    while (v != 0) begin v = v >> 1; bits++; end
    r.lzc  = WZ'(WS - bits);
    r.zero = (mag == 0);
    return r;
  endfunction

  function automatic beat_t zero_beat();
    beat_t b;
    b.s = '0; b.c = '0; b.a = '0;
    b.cc = 0; b.sub = 0; b.ems = 0; b.halt = 0; b.sa = 0; b.bc = 0;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    logic [63:0] r64;
    r64 = {$urandom, $urandom}; b.s = r64[WL-1:0];
    r64 = {$urandom, $urandom}; b.c = r64[WL-1:0];
    r64 = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: b.a = '1;
      1: b.a = WH'(r64[7:0]);
      default: b.a = r64[WH-1:0];
    endcase
    b.cc = r64[40]; b.sub = r64[41]; b.sa = r64[42]; b.bc = r64[43];
    b.ems  = ($urandom_range(0, 7) == 0);
    b.halt = ($urandom_range(0, 7) == 0);
    return b;
  endfunction

  task automatic apply(input beat_t b);
    csa_sum = b.s; csa_carry = b.c; carry_corr = b.cc; sub_sign = b.sub;
    exp_mv_sign = b.ems; mv_halt = b.halt; sign_aligned = b.sa;
    bc_special = b.bc; a_high = b.a;
  endtask

  function automatic res_t obs();
    res_t r;
    r = {pos_sum, adder_sign, sign_flip, minus_sticky, lzc, zero};
    return r;
  endfunction

  task automatic send_single(input beat_t b, output res_t r, output int lat);
    @(negedge clk);
    apply(b); valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid_i = 1'b0;
    while (!valid_o && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    r = obs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++; if (obs() !== res_t'(0)) begin n_err++; $display("FAIL reset_data: got %h want 0", obs()); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat_t b; res_t r; int lat;
    b = zero_beat(); b.s = 48'd11;
    send_single(b, r, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++; if (r.pos !== 74'd11 || r.flip !== 1'b0 || r.lzc !== 7'd70 || r.zero !== 1'b0) begin
      n_err++; $display("FAIL basic_value: got pos=%h flip=%b lzc=%0d zero=%b want 11/0/70/0", r.pos, r.flip, r.lzc, r.zero); end
    n_cmp++; if (r !== model(b)) begin n_err++; $display("FAIL basic_model: got %h want %h", r, model(b)); end
  endtask

  task automatic test_sign_flip();
    beat_t b; res_t r; int lat;
    logic [WS-1:0] want;
    b = zero_beat(); b.a = 27'h7FFFFFF;
    want = '0; want[48] = 1'b1;
    send_single(b, r, lat);
    n_cmp++; if (r.pos !== want || r.flip !== 1'b1 || r.asign !== 1'b1 || r.lzc !== 7'd25) begin
      n_err++; $display("FAIL sign_flip: got pos=%h flip=%b sign=%b lzc=%0d want %h/1/1/25", r.pos, r.flip, r.asign, r.lzc, want); end
    n_cmp++; if (r !== model(b)) begin n_err++; $display("FAIL sign_flip_model: got %h want %h", r, model(b)); end
  endtask

  task automatic test_mv_halt();
    beat_t b; res_t r; int lat;
    b = zero_beat(); b.halt = 1'b1; b.s = 48'hFF; b.a = 27'd5;
    send_single(b, r, lat);
    n_cmp++; if (r.pos !== 74'hFF || r.lzc !== 7'd66 || r.zero !== 1'b0) begin
      n_err++; $display("FAIL mv_halt: got pos=%h lzc=%0d zero=%b want ff/66/0", r.pos, r.lzc, r.zero); end
    b = zero_beat();
    send_single(b, r, lat);
    n_cmp++; if (r.pos !== 74'd0 || r.zero !== 1'b1 || r.lzc !== 7'd74) begin
      n_err++; $display("FAIL zero_result: got pos=%h zero=%b lzc=%0d want 0/1/74", r.pos, r.zero, r.lzc); end
  endtask

  task automatic test_exp_mv_sign();
    beat_t b; res_t r; int lat;
    logic [WS-1:0] want;
    b = zero_beat(); b.ems = 1'b1; b.sub = 1'b1; b.a = 27'd4;
    want = 74'd7 << 47;
    send_single(b, r, lat);
    n_cmp++; if (r.pos !== want || r.sticky !== 1'b1) begin
      n_err++; $display("FAIL ems_sub: got pos=%h sticky=%b want %h/1", r.pos, r.sticky, want); end
    b.bc = 1'b1;
    want = 74'd8 << 47;
    send_single(b, r, lat);
    n_cmp++; if (r.pos !== want || r.sticky !== 1'b0) begin
      n_err++; $display("FAIL ems_sub_bc: got pos=%h sticky=%b want %h/0", r.pos, r.sticky, want); end
    n_cmp++; if (r !== model(b)) begin n_err++; $display("FAIL ems_model: got %h want %h", r, model(b)); end
  endtask

  task automatic test_back_to_back();
    beat_t bq[$];
    res_t held;
    int sent = 0, got = 0, ready_low = 0;
    logic holding = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) bq.push_back(rand_beat());
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      ready_i = !(c >= 2 && c <= 5);
      if (sent < 5) begin apply(bq[sent]); valid_i = 1'b1; end else valid_i = 1'b0;
      #1;
      if (holding) begin
        n_cmp++;
        if (!valid_o || obs() !== held) begin n_err++; $display("FAIL stall_hold: got %h want %h", obs(), held); end
      end
      holding = valid_o && !ready_i;
      held = obs();
      if (!ready_o) ready_low++;
      if (valid_i && ready_o) begin exp_q.push_back(model(bq[sent])); sent++; end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra: got %h want none", obs()); end
        else begin
          if (obs() !== exp_q[0]) begin n_err++; $display("FAIL b2b_data: got %h want %h", obs(), exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
    end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", got); end
    n_cmp++; if (ready_low !== 4) begin n_err++; $display("FAIL b2b_ready_low: got %0d cycles want 4", ready_low); end
  endtask

  task automatic test_throughput();
    beat_t bq[$];
    int sent = 0, got = 0, ready_low = 0, first_out = -1, last_out = -1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) bq.push_back(rand_beat());
    ready_i = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (sent < 8) begin apply(bq[sent]); valid_i = 1'b1; end else valid_i = 1'b0;
      #1;
      if (!ready_o) ready_low++;
      if (valid_i && ready_o) begin exp_q.push_back(model(bq[sent])); sent++; end
      if (valid_o) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        n_cmp++;
        if (exp_q.size() == 0 || obs() !== exp_q[0]) begin n_err++; $display("FAIL tput_data: got %h", obs()); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    @(negedge clk); valid_i = 1'b0;
    n_cmp++; if (ready_low !== 0) begin n_err++; $display("FAIL tput_ready: got %0d low cycles want 0", ready_low); end
    n_cmp++; if (first_out !== 2 || last_out !== 9) begin
      n_err++; $display("FAIL tput_timing: got first=%0d last=%0d want 2/9", first_out, last_out); end
  endtask

  task automatic test_random();
    beat_t cur;
    res_t held;
    int got = 0, sent = 0;
    logic have = 1'b0, holding = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3000 && got < 150; c++) begin
      @(negedge clk);
      ready_i = ($urandom_range(0, 9) < 7);
      if (!have && sent < 150 && $urandom_range(0, 3) != 0) begin cur = rand_beat(); have = 1'b1; end
      if (have) apply(cur);
      valid_i = have;
      #1;
      if (holding) begin
        n_cmp++;
        if (!valid_o || obs() !== held) begin n_err++; $display("FAIL rand_hold: got %h want %h", obs(), held); end
      end
      holding = valid_o && !ready_i;
      held = obs();
      if (valid_i && ready_o) begin exp_q.push_back(model(cur)); have = 1'b0; sent++; end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_extra: got %h", obs()); end
        else begin
          if (obs() !== exp_q[0]) begin n_err++; $display("FAIL rand_data: got %h want %h", obs(), exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
    end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
    n_cmp++; if (got !== 150) begin n_err++; $display("FAIL rand_count: got %0d want 150", got); end
  endtask

  task automatic test_reset_mid();
    beat_t b; res_t r; int lat, stale = 0;
    ready_i = 1'b1;
    @(negedge clk); apply(rand_beat()); valid_i = 1'b1;
    @(negedge clk); apply(rand_beat());
    @(negedge clk); valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL mid_inflight: got valid=%b want 1", valid_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got valid=%b ready=%b want 0/1", valid_o, ready_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (valid_o) stale++; end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL mid_stale: got %0d stale beats want 0", stale); end
    b = rand_beat();
    send_single(b, r, lat);
    n_cmp++; if (lat !== 2 || r !== model(b)) begin
      n_err++; $display("FAIL mid_after: got lat=%0d %h want 2 %h", lat, r, model(b)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_sign_flip();
    test_mv_halt();
    test_exp_mv_sign();
    test_back_to_back();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grand_adder_pipe.md
Name: grand_adder_pipe

Overview:
- Pipelined, handshaked successor of the FMA final ("grand") adder. Sits between the Wallace/CSA stage and LZA/normaliser.
- Adds the CSA sum/carry low part, then increments the aligned-addend high part, and returns the magnitude with a sign-flip flag.
- New behaviour:
  - 2-stage pipeline with valid/ready backpressure.
  - Exact two's-complement negation on sign flip.
  - Built-in leading-zero count and zero flag.
  - All widths derived from PARM_MANT.

Parameters:
- PARM_MANT, 23, mantissa width M.
- Derived, not overridable:
  - WL = 2M+2: low width.
  - WH = M+4: high width.
  - WS = 3M+5: result width.
  - WZ = clog2(WS+1): LZC width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat.
- CSA_sum_i  in  WL  CSA sum vector.
- CSA_carry_i  in  WL  CSA carry vector; bit WL-1 is ignored.
- Carry_corr_i  in  1  corrected carry MSB from Wallace sign-extension suppression.
- Sub_Sign_i  in  1  effective subtraction; injected as carry-in at the LSB.
- Exp_mv_sign_i  in  1  product does not participate.
- Mv_halt_i  in  1  addend fully shifted out.
- Sign_aligned_i  in  1  aligned addend sign.
- A_Mant_aligned_high_i  in  WH  aligned addend high part.
- Bc_special_i  in  1  B or C is Inf, Zero or NaN.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts.
- PosSum_o  out  WS  result magnitude.
- Adder_sign_o  out  1  result sign.
- Sign_flip_o  out  1  raw sum was negative.
- Minus_sticky_bit_o  out  1  sticky bit for the Exp_mv_sign case.
- Lzc_o  out  WZ  leading zeros of PosSum_o.
- Zero_o  out  1  PosSum_o == 0.

Behaviour:
- Reset: asynchronous, active-low. While rst_ni=0:
  - Both stage valid flags are cleared, so valid_o=0.
  - All data registers are 0, so PosSum_o=0, Lzc_o=0, Zero_o=0 and all flags are 0.
  - ready_o=1.
- Reset asserted mid-operation discards all in-flight beats. No output beat is produced for them.
- Handshake:
  - An input beat is accepted on (valid_i & ready_o).
  - An output beat is transferred on (valid_o & ready_i).
  - Outputs hold stable while valid_o & ~ready_i.
  - ready_o is combinationally (~s1_valid | s1_adv).
  - s1_adv = ~s2_valid | ready_i.
  - This gives full throughput with no bubbles. ready_o has no combinational path from valid_i.
- Latency: an accepted beat appears on the outputs exactly 2 cycles later when not stalled.
- Stage 1, registered:
  - cv = {Exp_mv_sign_i ? 0 : Carry_corr_i, CSA_carry_i[WL-2:0], Sub_Sign_i}, width WL+1.
  - {lc, ls} = CSA_sum_i + cv, width WL+1.
  - Register lc, ls, the high operand and all control inputs.
- Stage 2, registered into the output stage:
  - T = {A_high + lc, ls} mod 2^(WH+WL), read as two's complement.
  - Sign_flip_o = T[WH+WL-1].
  - PosSum_o is chosen by priority:
    1. Mv_halt: zero-extended ls.
    2. Exp_mv_sign and Sub_Sign: ({A_high[M+2:0],1'b0} - ~Bc_special) << (2M+1), truncated to WS.
    3. Exp_mv_sign only: {A_high[M+2:0], WL zeros}.
    4. Sign_flip: (-T)[WS-1:0].
    5. Otherwise: T[WS-1:0].
  - Sign_flip_o is reported as T[MSB] even when Mv_halt or Exp_mv_sign overrides PosSum_o.
  - Adder_sign_o = Exp_mv_sign ? Sign_aligned : (Sign_flip ^ Sign_aligned).
  - Minus_sticky_bit_o = Exp_mv_sign & ~Bc_special.
  - Lzc_o = number of leading zeros of PosSum_o.
  - If PosSum_o is 0: Lzc_o = WS and Zero_o = 1.
- Wrap-around: all arithmetic is modulo its stated width. No saturation.

Test Plan (M=23, WS=74):
1. Reset, then S=11, C=0, A_high=0, all controls 0 → 2 cycles later PosSum_o=11, Sign_flip_o=0, Lzc_o=70, Zero_o=0.
2. A_high=27'h7FFFFFF, S=0, C=0, Sign_aligned=0 → PosSum_o=2^48, Sign_flip_o=1, Adder_sign_o=1, Lzc_o=25.
3. Mv_halt=1, S=0xFF, A_high=5 → PosSum_o=0xFF, Lzc_o=66. Separately S=0, C=0, A_high=0 → PosSum_o=0, Zero_o=1, Lzc_o=74.
4. Exp_mv_sign=1, Sub=1, A_high=4, Bc_special=0 → PosSum_o=7<<47, Minus_sticky_bit_o=1. Same with Bc_special=1 → PosSum_o=8<<47, sticky=0.
5. Five back-to-back beats with ready_i low for cycles 2–5:
   - ready_o drops once both stages are full.
   - Outputs hold stable during the stall.
   - All five results then emerge in order with none lost or duplicated.
   - With ready_i=1 throughout, throughput is 1 beat per cycle.
6. Assert rst_ni low while two beats are in flight → valid_o=0 immediately. After release, no stale beat appears and the next accepted beat arrives with latency 2.
